halt_report_sequencer: RTL and testbench
========================================

Name: halt_report_sequencer

Overview:
- Sequences the UART transmitter at the end of a program run on the accumulator CPU.
- While the CPU runs, it counts clock cycles. On the decoder's halt strobe (wr_uart), it freezes the CPU, captures PC, ACC and the cycle count, then sends them as a fixed byte frame through the uart_tx start/done handshake.
- It sits between the instruction decoder, the PC/ACC registers and the UART transmitter. It is the only master of uart_tx.

Parameters:
- PC_W, 11, program counter width; zero-extended to 2 bytes.
- DATA_W, 16, accumulator width; sent as 2 bytes.
- CNT_W, 32, cycle counter width; sent as 4 bytes.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  halt request from the decoder (wr_uart); level, sampled each cycle.
- restart  in  1  one-cycle pulse from the board button logic; ends a report and resumes the CPU.
- pc_in  in  PC_W  current PC value.
- acc_in  in  DATA_W  current accumulator value.
- cpu_en  out  1  CPU clock-enable; 1 = run, 0 = frozen.
- tx_start  out  1  one-cycle pulse that starts transmission of tx_data.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_done.
- tx_done  in  1  one-cycle pulse from uart_tx when its stop bit has finished.
- busy  out  1  high from the cycle after halt capture until the last tx_done.
- report_done  out  1  high in DONE state.

Behaviour:
- Reset (async, rst_n=0) sets: state=IDLE, cpu_en=1, tx_start=0, tx_data=0, busy=0, report_done=0, cycle_cnt=0, byte_idx=0.
- Frame is 9 bytes, MSB first within each field:
  - HDR_BYTE
  - PC[15:8], PC[7:0] (zero-extended to 16 bits)
  - ACC[15:8], ACC[7:0]
  - CNT[31:24], CNT[23:16], CNT[15:8], CNT[7:0]
- Cycle counter:
  - Increments by 1 on each cycle with cpu_en=1 and state=IDLE.
  - Wraps 2^CNT_W-1 -> 0 with no flag.
  - Holds in all other states. Clears to 0 on restart.
- IDLE:
  - halt=1 -> CAPTURE, with cpu_en=0 registered the same edge.
  - The halt cycle itself is counted, so a program that halts on its N-th cycle reports N.
- CAPTURE (1 cycle):
  - Latch pc_in, acc_in and cycle_cnt into the 72-bit frame shift register.
  - Set byte_idx=0 and busy=1. Go to SEND.
- SEND (1 cycle):
  - tx_data = frame byte[byte_idx]; tx_start=1. Go to WAIT.
- WAIT:
  - tx_start=0; tx_data held.
  - tx_done=1 and byte_idx<8 -> byte_idx+1, go to SEND.
  - tx_done=1 and byte_idx=8 -> busy=0, go to DONE.
  - tx_done is ignored in every state other than WAIT, including a same-cycle tx_done during SEND.
  - Minimum spacing between tx_start pulses is 2 cycles.
- DONE:
  - report_done=1, cpu_en=0.
  - restart=1 -> IDLE, with cpu_en=1, report_done=0 and cycle_cnt=0.
  - halt is ignored in DONE.
- Boundary and priority rules:
  - halt re-assertion during CAPTURE/SEND/WAIT: ignored; no second frame starts.
  - restart during CAPTURE/SEND/WAIT: ignored; a frame is never truncated.
  - restart in IDLE: clears cycle_cnt only.
  - restart and halt in the same IDLE cycle: restart wins; the counter clears and halt is sampled again next cycle.
  - rst_n mid-frame: immediate IDLE, tx_start deasserts asynchronously, and the partial frame is abandoned. uart_tx shares rst_n.
  - The latched frame is immune to pc_in/acc_in changes after CAPTURE.

Decomposition:
- Shared package bip_pkg holds:
  - the state enum {IDLE, CAPTURE, SEND, WAIT, DONE}
  - HDR_BYTE
  - FRAME_BYTES=9
  - the byte-index width constant (4)
- One natural sub-module: cycle_counter (CNT_W; ports en, clr, count). It is reused for profiling elsewhere.
- Frame select is a byte mux on byte_idx inside the top module, not a separate block.

Test Plan:
- Reset release, then 5 run cycles, then halt=1 with pc_in=11'h007 and acc_in=16'h1234 -> cpu_en=0 next edge. Bytes sent: A5,00,07,12,34,00,00,00,06.
- uart_tx model with 10-cycle tx_done latency -> exactly 9 tx_start pulses, each spaced 12 cycles; busy falls on the cycle after the 9th tx_done; report_done=1.
- Change pc_in/acc_in to 11'h7FF/16'hFFFF after CAPTURE -> frame still carries 00,07,12,34.
- halt held high throughout the frame, plus restart pulsed at byte 4 -> no second frame, no truncation. Restart in DONE -> cpu_en=1 and cycle_cnt=0; the next report counts from 1.
- Preload cycle_cnt to 32'hFFFFFFFF (force), run 2 cycles, halt -> count bytes 00,00,00,01 (wrap).
- Assert rst_n=0 while in WAIT on byte 3 -> tx_start=0, busy=0, cpu_en=1 immediately. A subsequent halt sends a complete fresh frame starting with A5.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared types and constants for the halt report sequencer and its helpers.
package bip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         FRAME_BYTES = 9;
    localparam int         IDX_W       = 4;

    // Frame layout: header, PC, ACC, cycle count; MSB first within each field.
    function automatic logic [8*FRAME_BYTES-1:0] build_frame(
        input logic [7:0]  hdr,
        input logic [15:0] pc,
        input logic [15:0] acc,
        input logic [31:0] cnt
    );
        return {hdr, pc, acc, cnt};
    endfunction

endpackage

// File: rtl/halt_report_sequencer_cycle_counter.sv
// Free-running run-time counter with clear priority over enable; wraps silently.
module cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/halt_report_sequencer.sv
// Freezes the CPU on halt, then streams header, PC, ACC and cycle count
// through the uart_tx start/done handshake until restart resumes the CPU.
module halt_report_sequencer
    import bip_pkg::*;
#(
    parameter int         PC_W     = 11,
    parameter int         DATA_W   = 16,
    parameter int         CNT_W    = 32,
    parameter logic [7:0] HDR_BYTE = bip_pkg::HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              restart,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] acc_in,
    output logic              cpu_en,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              report_done
);

    localparam int FRAME_W = 8 * FRAME_BYTES;

    state_t             state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               report_done_q, report_done_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [7:0]         frame_byte;
    logic               cnt_en;
    logic               cnt_clr;

    // Restart only clears the counter where it is honoured (IDLE and DONE).
    assign cnt_en  = cpu_en_q && (state_q == IDLE);
    assign cnt_clr = restart && ((state_q == IDLE) || (state_q == DONE));

    cycle_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .count(cycle_cnt)
    );

    always_comb begin
        case (byte_idx_q)
            4'd0:    frame_byte = frame_q[71:64];
            4'd1:    frame_byte = frame_q[63:56];
            4'd2:    frame_byte = frame_q[55:48];
            4'd3:    frame_byte = frame_q[47:40];
            4'd4:    frame_byte = frame_q[39:32];
            4'd5:    frame_byte = frame_q[31:24];
            4'd6:    frame_byte = frame_q[23:16];
            4'd7:    frame_byte = frame_q[15:8];
            4'd8:    frame_byte = frame_q[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cpu_en_d      = cpu_en_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        busy_d        = busy_q;
        report_done_d = report_done_q;
        byte_idx_d    = byte_idx_q;
        frame_d       = frame_q;
        case (state_q)
            IDLE: begin
                if (!restart && halt) begin
                    state_d  = CAPTURE;
                    cpu_en_d = 1'b0;
                end
            end
            CAPTURE: begin
                frame_d    = build_frame(HDR_BYTE, 16'(pc_in), 16'(acc_in), 32'(cycle_cnt));
                byte_idx_d = '0;
                busy_d     = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                tx_data_d  = frame_byte;
                tx_start_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q < IDX_W'(FRAME_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = SEND;
                    end else begin
                        busy_d        = 1'b0;
                        report_done_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                cpu_en_d = 1'b0;
                if (restart) begin
                    cpu_en_d      = 1'b1;
                    report_done_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cpu_en_q      <= 1'b1;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
            report_done_q <= 1'b0;
            byte_idx_q    <= '0;
            frame_q       <= '0;
        end else begin
            state_q       <= state_d;
            cpu_en_q      <= cpu_en_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            report_done_q <= report_done_d;
            byte_idx_q    <= byte_idx_d;
            frame_q       <= frame_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign report_done = report_done_q;

endmodule

// File: tb/tb_halt_report_sequencer.sv
// Scoreboard bench for halt_report_sequencer with a 10-cycle-latency uart_tx model.
module tb_halt_report_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] pc_in = '0;
    logic [15:0] acc_in = '0;
    logic        tx_done = 1'b0;
    logic        cpu_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        report_done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          starts = 0;
    int          dones = 0;
    int          last_start = -1;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_byte;

    halt_report_sequencer #(
        .PC_W(11), .DATA_W(16), .CNT_W(32), .HDR_BYTE(8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt       (halt),
        .restart    (restart),
        .pc_in      (pc_in),
        .acc_in     (acc_in),
        .cpu_en     (cpu_en),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .report_done(report_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // uart_tx stand-in: tx_done pulses 10 cycles after each tx_start is seen.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt = 0;
            tx_done  = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (done_cnt != 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done = 1'b1;
                    dones++;
                end
            end else if (tx_start === 1'b1) begin
                done_cnt = 10;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && tx_start === 1'b1) begin
            starts++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_tx_start: got byte %h, required no transmission", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    n_fail++;
                    $display("[TB] FAIL frame_byte: got %h, required %h", tx_data, exp_byte);
                end
            end
            if (last_start >= 0) begin
                n_checks++;
                if (cyc - last_start != 12) begin
                    n_fail++;
                    $display("[TB] FAIL start_spacing: got %0d cycles, required 12", cyc - last_start);
                end
            end
            last_start = cyc;
        end
    end

    task automatic push_frame(input logic [10:0] pc, input logic [15:0] acc, input logic [31:0] cnt);
        logic [15:0] p;
        p = {5'b0, pc};
        exp_q.push_back(8'hA5);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        exp_q.push_back(acc[15:8]);
        exp_q.push_back(acc[7:0]);
        exp_q.push_back(cnt[31:24]);
        exp_q.push_back(cnt[23:16]);
        exp_q.push_back(cnt[15:8]);
        exp_q.push_back(cnt[7:0]);
        starts     = 0;
        dones      = 0;
        last_start = -1;
    endtask

    task automatic wait_report(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (report_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (starts == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (cpu_en !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cpu_en: got %b, required 1", cpu_en); end
        if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        if (report_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_report_done: got %b, required 0", report_done); end
    endtask

    task automatic test_basic_frame();
        bit ok;
        pc_in  = 11'h007;
        acc_in = 16'h1234;
        push_frame(11'h007, 16'h1234, 32'd6);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_freeze: cpu_en got %b, required 0", cpu_en); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL capture_busy: got %b, required 1", busy); end
        pc_in  = 11'h7FF;
        acc_in = 16'hFFFF;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (dones == 9) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks += 2;
        if (!ok) begin n_fail++; $display("[TB] FAIL ninth_done_timeout: got %0d tx_done, required 9", dones); end
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_during_last_done: got %b, required 1", busy); end
        @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_after_last_done: got %b, required 0", busy); end
        if (report_done !== 1'b1) begin n_fail++; $display("[TB] FAIL report_done_set: got %b, required 1", report_done); end
        if (cpu_en !== 1'b0) begin n_fail++; $display("[TB] FAIL done_cpu_en: got %b, required 0", cpu_en); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL basic_bytes_left: got %0d unsent, required 0", exp_q.size()); end
        repeat (20) @(negedge clk);
        n_checks += 2;
        if (starts != 9) begin n_fail++; $display("[TB] FAIL basic_start_count: got %0d, required 9", starts); end
        if (report_done !== 1'b1) begin n_fail++; $display("[TB] FAIL done_holds: got %b, required 1", report_done); end
    endtask

    task automatic test_halt_held_restart();
        bit ok;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks += 2;
        if (cpu_en !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_cpu_en: got %b, required 1", cpu_en); end
        if (report_done !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_report_done: got %b, required 0", report_done); end
        pc_in  = 11'h3C5;
        acc_in = 16'hBEEF;
        push_frame(11'h3C5, 16'hBEEF, 32'd1);
        halt = 1'b1;
        wait_starts(4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL held_start4_timeout: got %0d starts, required 4", starts); end
        do_restart();
        wait_report(ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("[TB] FAIL held_report_timeout: report_done got %b, required 1", report_done); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL held_bytes_left: got %0d unsent, required 0", exp_q.size()); end
        if (starts != 9) begin n_fail++; $display("[TB] FAIL held_start_count: got %0d, required 9", starts); end
        repeat (30) @(negedge clk);
        n_checks += 2;
        if (starts != 9) begin n_fail++; $display("[TB] FAIL halt_in_done_ignored: got %0d starts, required 9", starts); end
        if (report_done !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_in_done_state: got %b, required 1", report_done); end
        halt = 1'b0;
    endtask

    task automatic test_restart_halt_same_cycle();
        bit ok;
        do_restart();
        repeat (3) @(negedge clk);
        pc_in  = 11'h155;
        acc_in = 16'h0A0B;
        push_frame(11'h155, 16'h0A0B, 32'd1);
        halt    = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_wins: cpu_en got %b, required 1", cpu_en); end
        @(negedge clk);
        halt = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_resampled: cpu_en got %b, required 0", cpu_en); end
        wait_report(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("[TB] FAIL race_report_timeout: report_done got %b, required 1", report_done); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL race_bytes_left: got %0d unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        do_restart();
        force dut.u_cycle_counter.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_cycle_counter.count_q;
        @(negedge clk);
        pc_in  = 11'h400;
        acc_in = 16'h00FF;
        push_frame(11'h400, 16'h00FF, 32'd1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_report(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("[TB] FAIL wrap_report_timeout: report_done got %b, required 1", report_done); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL wrap_bytes_left: got %0d unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_restart();
        repeat (2) @(negedge clk);
        pc_in  = 11'h2AA;
        acc_in = 16'h5566;
        push_frame(11'h2AA, 16'h5566, 32'd3);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_starts(4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL midrst_start4_timeout: got %0d starts, required 4", starts); end
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_tx_start: got %b, required 0", tx_start); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy); end
        if (cpu_en !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_cpu_en: got %b, required 1", cpu_en); end
        if (report_done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_report_done: got %b, required 0", report_done); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        pc_in  = 11'h011;
        acc_in = 16'h2233;
        push_frame(11'h011, 16'h2233, 32'd5);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_report(ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("[TB] FAIL fresh_report_timeout: report_done got %b, required 1", report_done); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL fresh_bytes_left: got %0d unsent, required 0", exp_q.size()); end
        if (starts != 9) begin n_fail++; $display("[TB] FAIL fresh_start_count: got %0d, required 9", starts); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_halt_held_restart();
        test_restart_halt_same_cycle();
        test_counter_wrap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
